// File: rtl/adder_result_capture_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : adder_result_capture_if
// Description : Bundle between the ripple adder / upstream sequencer, the
//               result capture stage, and the downstream consumer.
//               master : the capture stage (drives busy, result and flags)
//               slave  : the environment (drives start, adder outputs,
//                        out_ready, clear_sticky)
// Signals     : start, subtract_in, sum_in, carryout_in, overflow_in,
//               busy, out_valid, out_ready, result, op_sub, carry_flag,
//               overflow_flag, zero_flag, negative_flag, sticky_overflow,
//               clear_sticky, op_count[15:0]
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface adder_result_capture_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             subtract_in;
    logic [WIDTH-1:0] sum_in;
    logic             carryout_in;
    logic             overflow_in;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             op_sub;
    logic             carry_flag;
    logic             overflow_flag;
    logic             zero_flag;
    logic             negative_flag;
    logic             sticky_overflow;
    logic             clear_sticky;
    logic [15:0]      op_count;

    modport master (
        input  start, subtract_in, sum_in, carryout_in, overflow_in,
               out_ready, clear_sticky,
        output busy, out_valid, result, op_sub, carry_flag, overflow_flag,
               zero_flag, negative_flag, sticky_overflow, op_count
    );

    modport slave (
        output start, subtract_in, sum_in, carryout_in, overflow_in,
               out_ready, clear_sticky,
        input  busy, out_valid, result, op_sub, carry_flag, overflow_flag,
               zero_flag, negative_flag, sticky_overflow, op_count
    );
endinterface
`default_nettype wire

// File: rtl/adder_result_capture.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : adder_result_capture
// Description : Clocked stage behind the combinational ripple adder. After a
//               start it waits SETTLE_CYCLES edges for the adder to settle,
//               registers sum and derived flags (C, V, Z, N), and offers them
//               to the consumer through a valid/ready handshake. Keeps a
//               sticky overflow bit and a 16-bit count of accepted results.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset, clears all state
//               bus   - adder_result_capture_if.master (see interface)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module adder_result_capture #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_W         = 8
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    adder_result_capture_if.master       bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_op_sub;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;
    logic             r_negative;
    logic             r_sticky;
    logic [15:0]      r_op_count;

    logic             w_capture;
    logic             w_transfer;

    assign w_capture  = (r_state == ST_SETTLE) && (r_cnt == '0);
    assign w_transfer = (r_state == ST_HOLD) && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_result   <= '0;
            r_op_sub   <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_sticky   <= 1'b0;
            r_op_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state  <= ST_SETTLE;
                        r_cnt    <= c_cnt_load;
                        r_op_sub <= bus.subtract_in;
                    end
                end
                ST_SETTLE: begin
                    if (w_capture) begin
                        r_state    <= ST_HOLD;
                        r_result   <= bus.sum_in;
                        r_carry    <= bus.carryout_in;
                        r_overflow <= bus.overflow_in;
                        r_zero     <= (bus.sum_in == '0);
                        r_negative <= bus.sum_in[WIDTH-1];
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (w_transfer) begin
                        r_op_count <= r_op_count + 16'd1;
                        // A start coinciding with the transfer launches the
                        // next operation immediately; otherwise it is dropped.
                        if (bus.start) begin
                            r_state  <= ST_SETTLE;
                            r_cnt    <= c_cnt_load;
                            r_op_sub <= bus.subtract_in;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Setting has priority over clearing on the same edge so an
            // overflow is never lost.
            if (w_capture && bus.overflow_in) begin
                r_sticky <= 1'b1;
            end else if (bus.clear_sticky) begin
                r_sticky <= 1'b0;
            end
        end
    end

    // busy and out_valid are pure decodes of the state register, so the
    // asynchronous reset removes them without waiting for a clock edge.
    assign bus.busy            = (r_state != ST_IDLE);
    assign bus.out_valid       = (r_state == ST_HOLD);
    assign bus.result          = r_result;
    assign bus.op_sub          = r_op_sub;
    assign bus.carry_flag      = r_carry;
    assign bus.overflow_flag   = r_overflow;
    assign bus.zero_flag       = r_zero;
    assign bus.negative_flag   = r_negative;
    assign bus.sticky_overflow = r_sticky;
    assign bus.op_count        = r_op_count;

endmodule
`default_nettype wire
